// File: rtl/cmos_pkg.sv
// rtl/cmos_pkg.sv - shared types and constants for the camera capture path
package cmos_pkg;

  localparam int RGB444_W = 12;

  typedef enum logic [1:0] {
    RGB565 = 2'b00,
    RGB444 = 2'b01,
    GRAY   = 2'b10
  } pixel_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } capture_state_t;

  // The unused 11 encoding behaves as RGB565.
  function automatic pixel_mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   decode_mode = RGB444;
      2'b10:   decode_mode = GRAY;
      default: decode_mode = RGB565;
    endcase
  endfunction

endpackage

// File: rtl/cmos_pixel_packer.sv
// rtl/cmos_pixel_packer.sv - pairs camera bytes and converts them to RGB444
module cmos_pixel_packer
  import cmos_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic                byte_valid_i,
  input  logic [7:0]          byte_i,
  input  pixel_mode_t         mode_i,
  output logic                phase_o,
  output logic [RGB444_W-1:0] pixel_o
);

  logic [7:0]          byte0_q;
  logic [RGB444_W-1:0] pixel_n;

  // Build the 12-bit word from the stored first byte and the incoming second byte
  always_comb begin
    pixel_n = '0;
    case (mode_i)
      RGB444:  pixel_n = {byte0_q[3:0], byte_i};
      GRAY:    pixel_n = {3{byte0_q[7:4]}};
      default: pixel_n = {byte0_q[7:4], byte0_q[2:0], byte_i[7], byte_i[4:1]};
    endcase
  end

  // Even phase stores byte0, odd phase registers the finished pixel
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_o <= 1'b0;
      byte0_q <= '0;
      pixel_o <= '0;
    end else if (clear_i) begin
      phase_o <= 1'b0;
    end else if (byte_valid_i) begin
      if (!phase_o) begin
        byte0_q <= byte_i;
        phase_o <= 1'b1;
      end else begin
        pixel_o <= pixel_n;
        phase_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmos_frame_writer.sv
// rtl/cmos_frame_writer.sv - camera byte stream to banked VRAM capture engine
module cmos_frame_writer
  import cmos_pkg::*;
#(
  parameter  int ACTIVE_COLUMNS  = 640,
  parameter  int ACTIVE_ROWS     = 480,
  parameter  int DECIMATE        = 2,
  parameter  int DOUBLE_BUFFER   = 1,
  parameter  int VRAM_DATA_WIDTH = 12,
  localparam int FRAME_WORDS     = (ACTIVE_COLUMNS/DECIMATE)*(ACTIVE_ROWS/DECIMATE),
  localparam int VRAM_ADDR_WIDTH = $clog2((DOUBLE_BUFFER+1)*FRAME_WORDS)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       vsync_cmos_i,
  input  logic                       href_cmos_i,
  input  logic                       byte_valid_i,
  input  logic [7:0]                 pixel_data_cmos_i,
  input  logic                       capture_en_i,
  input  logic [1:0]                 mode_i,
  input  logic                       err_clr_i,
  output logic                       wr_en_o,
  output logic [VRAM_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [VRAM_DATA_WIDTH-1:0] wr_data_o,
  output logic                       frame_done_o,
  output logic                       display_bank_o,
  output logic                       line_err_o,
  output logic                       frame_err_o
);

  // Counters saturate one past the active size so over-long lines/frames stay detectable.
  localparam int XW = $clog2(ACTIVE_COLUMNS + 2);
  localparam int YW = $clog2(ACTIVE_ROWS + 2);
  localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  localparam logic [XW-1:0] X_END = XW'(ACTIVE_COLUMNS);
  localparam logic [XW-1:0] X_SAT = XW'(ACTIVE_COLUMNS + 1);
  localparam logic [YW-1:0] Y_END = YW'(ACTIVE_ROWS);
  localparam logic [YW-1:0] Y_SAT = YW'(ACTIVE_ROWS + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DECIMATE - 1);
  localparam logic [VRAM_ADDR_WIDTH-1:0] BANK1_BASE = VRAM_ADDR_WIDTH'(FRAME_WORDS);

  capture_state_t state_q, state_n;
  pixel_mode_t    mode_q;

  logic vsync_q, vsync_qq, href_q;
  logic vsync_rise, vsync_fall, href_fall;

  logic [XW-1:0]              x_cnt;
  logic [YW-1:0]              y_cnt;
  logic [DW-1:0]              x_mod, y_mod;
  logic [VRAM_ADDR_WIDTH-1:0] wcount;
  logic                       write_bank;
  logic                       line_err_frame;

  logic                       frame_start, frame_end, frame_ok;
  logic                       accept, pixel_strobe, keep;
  logic                       line_bad, line_err_set, frame_err_set;
  logic                       packer_clear, phase;
  logic [RGB444_W-1:0]        pixel;
  logic [VRAM_ADDR_WIDTH-1:0] bank_base;

  // Vsync edges use a two-stage history so frame_done lands two cycles after vsync rises
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
    end else begin
      vsync_q  <= vsync_cmos_i;
      vsync_qq <= vsync_q;
      href_q   <= href_cmos_i;
    end
  end

  assign vsync_rise = vsync_q & ~vsync_qq;
  assign vsync_fall = ~vsync_q & vsync_qq;
  assign href_fall  = href_q & ~href_cmos_i;

  assign frame_start   = (state_q == IDLE) && vsync_fall && capture_en_i;
  assign frame_end     = (state_q == ACTIVE) && vsync_rise;
  assign frame_ok      = (y_cnt == Y_END) && !line_err_frame;
  assign accept        = (state_q == ACTIVE) && href_cmos_i && byte_valid_i;
  assign pixel_strobe  = accept && phase;
  assign keep          = pixel_strobe && (x_cnt < X_END) && (y_cnt < Y_END) &&
                         (x_mod == '0) && (y_mod == '0);
  assign line_bad      = (x_cnt != X_END) || phase;
  assign line_err_set  = (state_q == ACTIVE) && href_fall && line_bad;
  assign frame_err_set = frame_end && !frame_ok;
  assign packer_clear  = frame_start || ((state_q == ACTIVE) && href_fall);
  assign bank_base     = write_bank ? BANK1_BASE : '0;

  cmos_pixel_packer u_packer (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .clear_i      (packer_clear),
    .byte_valid_i (accept),
    .byte_i       (pixel_data_cmos_i),
    .mode_i       (mode_q),
    .phase_o      (phase),
    .pixel_o      (pixel)
  );

  assign wr_data_o = pixel;

  // Capture state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_n;
  end

  // Frame starts on a qualified vsync fall and ends on the next vsync rise
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_n = ACTIVE;
      ACTIVE:  if (vsync_rise)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Position counters, VRAM write port, bank swapping and completion pulse
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mode_q         <= RGB565;
      x_cnt          <= '0;
      y_cnt          <= '0;
      x_mod          <= '0;
      y_mod          <= '0;
      wcount         <= '0;
      line_err_frame <= 1'b0;
      wr_en_o        <= 1'b0;
      wr_addr_o      <= '0;
      frame_done_o   <= 1'b0;
      write_bank     <= (DOUBLE_BUFFER != 0);
      display_bank_o <= 1'b0;
    end else begin
      wr_en_o      <= 1'b0;
      frame_done_o <= 1'b0;
      if (frame_start) begin
        mode_q         <= decode_mode(mode_i);
        x_cnt          <= '0;
        y_cnt          <= '0;
        x_mod          <= '0;
        y_mod          <= '0;
        wcount         <= '0;
        line_err_frame <= 1'b0;
      end else if (state_q == ACTIVE) begin
        if (pixel_strobe) begin
          if (x_cnt != X_SAT) x_cnt <= x_cnt + 1'b1;
          x_mod <= (x_mod == D_LAST) ? '0 : x_mod + 1'b1;
          if (keep) begin
            wr_en_o   <= 1'b1;
            wr_addr_o <= bank_base + wcount;
            wcount    <= wcount + 1'b1;
          end
        end
        if (href_fall) begin
          x_cnt <= '0;
          x_mod <= '0;
          if (y_cnt != Y_SAT) y_cnt <= y_cnt + 1'b1;
          y_mod <= (y_mod == D_LAST) ? '0 : y_mod + 1'b1;
          if (line_bad) line_err_frame <= 1'b1;
        end
        if (frame_end && frame_ok) begin
          frame_done_o <= 1'b1;
          if (DOUBLE_BUFFER != 0) begin
            display_bank_o <= write_bank;
            write_bank     <= ~write_bank;
          end
        end
      end
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      line_err_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (line_err_set)   line_err_o <= 1'b1;
      else if (err_clr_i) line_err_o <= 1'b0;
      if (frame_err_set)  frame_err_o <= 1'b1;
      else if (err_clr_i) frame_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmos_frame_writer.sv
// tb/tb_cmos_frame_writer.sv - directed bench for cmos_frame_writer
module tb_cmos_frame_writer;

  logic       clk = 1'b0;
  logic       rst, vsync, href, bv, cap_en, cap_en2, err_clr;
  logic [7:0] pdata;
  logic [1:0] mode;

  logic        wr_en1, frame_done1, display_bank1, line_err1, frame_err1;
  logic [5:0]  wr_addr1;
  logic [11:0] wr_data1;
  logic        wr_en2, frame_done2, display_bank2, line_err2, frame_err2;
  logic [3:0]  wr_addr2;
  logic [11:0] wr_data2;

  int total = 0;
  int bad   = 0;

  logic [31:0] log_a1[$], log_d1[$], log_a2[$], log_d2[$];
  int fd1_cnt = 0;
  int fd2_cnt = 0;

  always #5 clk = ~clk;

  cmos_frame_writer #(.ACTIVE_COLUMNS(8), .ACTIVE_ROWS(4), .DECIMATE(1),
                      .DOUBLE_BUFFER(1), .VRAM_DATA_WIDTH(12)) dut1 (
    .clk_i(clk), .reset_i(rst), .vsync_cmos_i(vsync), .href_cmos_i(href),
    .byte_valid_i(bv), .pixel_data_cmos_i(pdata), .capture_en_i(cap_en),
    .mode_i(mode), .err_clr_i(err_clr), .wr_en_o(wr_en1), .wr_addr_o(wr_addr1),
    .wr_data_o(wr_data1), .frame_done_o(frame_done1), .display_bank_o(display_bank1),
    .line_err_o(line_err1), .frame_err_o(frame_err1));

  cmos_frame_writer #(.ACTIVE_COLUMNS(8), .ACTIVE_ROWS(4), .DECIMATE(2),
                      .DOUBLE_BUFFER(1), .VRAM_DATA_WIDTH(12)) dut2 (
    .clk_i(clk), .reset_i(rst), .vsync_cmos_i(vsync), .href_cmos_i(href),
    .byte_valid_i(bv), .pixel_data_cmos_i(pdata), .capture_en_i(cap_en2),
    .mode_i(mode), .err_clr_i(err_clr), .wr_en_o(wr_en2), .wr_addr_o(wr_addr2),
    .wr_data_o(wr_data2), .frame_done_o(frame_done2), .display_bank_o(display_bank2),
    .line_err_o(line_err2), .frame_err_o(frame_err2));

  always @(negedge clk) begin
    if (wr_en1) begin
      log_a1.push_back(32'(wr_addr1));
      log_d1.push_back(32'(wr_data1));
    end
    if (wr_en2) begin
      log_a2.push_back(32'(wr_addr2));
      log_d2.push_back(32'(wr_data2));
    end
    if (frame_done1) fd1_cnt++;
    if (frame_done2) fd2_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int rows, input int short_row, input logic [7:0] b0,
                           input logic [7:0] b1, input bit pat, input int en_row,
                           input logic en_val, input int abort_pix);
    int pcount;
    int ncols;
    pcount = 0;
    vsync = 1'b1;
    repeat (4) step();
    vsync = 1'b0;
    repeat (4) step();
    for (int r = 0; r < rows; r++) begin
      if (r == en_row) cap_en = en_val;
      ncols = (r == short_row) ? 7 : 8;
      for (int c = 0; c < ncols; c++) begin
        if (abort_pix > 0 && pcount == abort_pix) begin
          bv = 1'b0;
          return;
        end
        href  = 1'b1;
        bv    = 1'b1;
        pdata = pat ? 8'(r) : b0;
        step();
        pdata = pat ? {4'(c), 4'h5} : b1;
        step();
        pcount++;
      end
      href = 1'b0;
      bv   = 1'b0;
      repeat (3) step();
    end
    vsync = 1'b1;
  endtask

  task automatic check_writes1(input string tag, input int n0, input int n_exp,
                               input int addr0, input logic [11:0] data_exp);
    check({tag, "_nwr"}, 32'(log_a1.size() - n0), 32'(n_exp));
    for (int i = 0; i < n_exp && (n0 + i) < log_a1.size(); i++) begin
      check({tag, "_addr"}, log_a1[n0 + i], 32'(addr0 + i));
      check({tag, "_data"}, log_d1[n0 + i], 32'(data_exp));
    end
  endtask

  task automatic full_frame(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                            input int en_row, input logic en_val, input int addr0,
                            input logic [11:0] data_exp, input logic disp);
    int n0;
    int f0;
    n0 = log_a1.size();
    f0 = fd1_cnt;
    run_frame(4, -1, b0, b1, 1'b0, en_row, en_val, 0);
    repeat (5) step();
    check_writes1(tag, n0, 32, addr0, data_exp);
    check({tag, "_fd"}, 32'(fd1_cnt - f0), 32'd1);
    check({tag, "_disp"}, 32'(display_bank1), 32'(disp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en1), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr1), 0);
    check({tag, "_wr_data"}, 32'(wr_data1), 0);
    check({tag, "_fd"}, 32'(frame_done1), 0);
    check({tag, "_disp"}, 32'(display_bank1), 0);
    check({tag, "_line_err"}, 32'(line_err1), 0);
    check({tag, "_frame_err"}, 32'(frame_err1), 0);
  endtask

  initial begin
    int n0;
    int f0;
    int m0;
    int g0;
    rst = 1'b1; vsync = 1'b0; href = 1'b0; bv = 1'b0; pdata = 8'h00;
    cap_en = 1'b1; cap_en2 = 1'b0; mode = 2'b01; err_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset_outputs("rst");

    // clean frame into bank 1, with exact frame_done timing
    n0 = log_a1.size(); f0 = fd1_cnt;
    run_frame(4, -1, 8'h0A, 8'hBC, 1'b0, -1, 1'b1, 0);
    step();
    check("s1_fd_early", 32'(frame_done1), 0);
    step();
    check("s1_fd_pulse", 32'(frame_done1), 1);
    check("s1_disp", 32'(display_bank1), 1);
    step();
    check("s1_fd_end", 32'(frame_done1), 0);
    repeat (3) step();
    check_writes1("s1", n0, 32, 32, 12'hABC);
    check("s1_fd_cnt", 32'(fd1_cnt - f0), 1);

    // second clean frame lands in bank 0
    full_frame("s2", 8'h0A, 8'hBC, -1, 1'b1, 0, 12'hABC, 1'b0);

    // RGB565 red plus full blue, then gray
    mode = 2'b00;
    full_frame("s3_565", 8'hF8, 8'h1F, -1, 1'b1, 32, 12'hF0F, 1'b1);
    mode = 2'b10;
    full_frame("s4_gray", 8'h90, 8'h80, -1, 1'b1, 0, 12'h999, 1'b0);
    mode = 2'b01;

    // short line: errors, no completion, bank kept
    n0 = log_a1.size(); f0 = fd1_cnt;
    run_frame(4, 1, 8'h0A, 8'hBC, 1'b0, -1, 1'b1, 0);
    step();
    step();
    check("s5_fd", 32'(frame_done1), 0);
    check("s5_line_err", 32'(line_err1), 1);
    check("s5_frame_err", 32'(frame_err1), 1);
    check("s5_disp", 32'(display_bank1), 0);
    repeat (3) step();
    check("s5_nwr", 32'(log_a1.size() - n0), 31);
    check("s5_fd_cnt", 32'(fd1_cnt - f0), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("s5_line_clr", 32'(line_err1), 0);
    check("s5_frame_clr", 32'(frame_err1), 0);

    // capture disabled at frame start, enabled mid-frame
    cap_en = 1'b0;
    n0 = log_a1.size(); f0 = fd1_cnt;
    run_frame(4, -1, 8'h0A, 8'hBC, 1'b0, 1, 1'b1, 0);
    repeat (5) step();
    check("s6_nwr", 32'(log_a1.size() - n0), 0);
    check("s6_fd_cnt", 32'(fd1_cnt - f0), 0);

    // enable dropped mid-frame still completes; same bank as the failed frame
    full_frame("s7", 8'h0A, 8'hBC, 2, 1'b0, 32, 12'hABC, 1'b1);
    cap_en = 1'b1;

    // reset after 10 writes
    n0 = log_a1.size(); f0 = fd1_cnt;
    run_frame(4, -1, 8'h0A, 8'hBC, 1'b0, -1, 1'b1, 10);
    rst  = 1'b1;
    href = 1'b0;
    step();
    check_reset_outputs("s8");
    rst = 1'b0;
    repeat (3) step();
    check("s8_nwr", 32'(log_a1.size() - n0), 10);
    if (log_a1.size() == n0 + 10) begin
      check("s8_first_addr", log_a1[n0], 0);
      check("s8_last_addr", log_a1[n0 + 9], 9);
    end
    check("s8_fd_cnt", 32'(fd1_cnt - f0), 0);

    full_frame("s9", 8'h0A, 8'hBC, -1, 1'b1, 32, 12'hABC, 1'b1);

    // decimate by 2 on the second instance only
    cap_en = 1'b0;
    cap_en2 = 1'b1;
    n0 = log_a1.size(); m0 = log_a2.size(); g0 = fd2_cnt;
    run_frame(4, -1, 8'h00, 8'h00, 1'b1, -1, 1'b1, 0);
    repeat (5) step();
    check("s10_dut1_nwr", 32'(log_a1.size() - n0), 0);
    check("s10_nwr", 32'(log_a2.size() - m0), 8);
    for (int i = 0; i < 8 && (m0 + i) < log_a2.size(); i++) begin
      check("s10_addr", log_a2[m0 + i], 32'(8 + i));
      check("s10_data", log_d2[m0 + i], 32'((((i / 4) * 2) << 8) | (((i % 4) * 2) << 4) | 5));
    end
    check("s10_fd_cnt", 32'(fd2_cnt - g0), 1);
    check("s10_disp", 32'(display_bank2), 1);
    check("s10_line_err", 32'(line_err2), 0);
    check("s10_frame_err", 32'(frame_err2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
